lsu_mem_ctrl: RTL and testbench
===============================

Name: lsu_mem_ctrl

Overview:
- Load/store sequencer between the execute stage and a single-port 32-bit data memory bus.
- Accepts one RV32I load/store at a time: LB/LH/LW/LBU/LHU and SB/SH/SW, selected by funct3 load/store encodings.
- Generates a word-aligned bus address, byte enables and lane-shifted write data; waits for the bus handshake.
- Returns sign-/zero-extended load data, or a fault.

Parameters:
- ADDR_W, 32, byte address width on request and bus.
- TIMEOUT, 255, max cycles from grant to mem_rvalid before fault; 0 disables the timeout.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  execute stage presents an access
- req_ready  out  1  controller can accept (high only in IDLE)
- req_store  in  1  1=store (funct3 per store encoding), 0=load
- req_funct3  in  3  LB=000 LH=001 LW=010 LBU=100 LHU=101; SB=000 SH=001 SW=010
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, LSB-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data (0 for stores and faults)
- resp_fault  out  1  valid with resp_valid: misaligned, illegal funct3, or timeout
- mem_req  out  1  bus request, held until mem_gnt
- mem_gnt  in  1  bus accepts request this cycle
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  word address (bits [1:0]=0)
- mem_be  out  4  byte enables
- mem_wdata  out  32  lane-aligned write data
- mem_rvalid  in  1  read data / write ack
- mem_rdata  in  32  read word
- busy  out  1  state != IDLE

Behaviour:
- Reset: state=IDLE; every output 0 except req_ready=1; all internal registers and the timeout counter cleared. Asserting rst_n low mid-transaction aborts it immediately, with no response; a later mem_rvalid arriving in IDLE is ignored.
- FSM states IDLE, ISSUE, WAIT, RESP (SPLIT adds ISSUE2, WAIT2).
- IDLE: on req_valid at edge T, latch the request, then decode:
  - illegal funct3 (load 011/110/111, store >=011): go to RESP with fault.
  - misaligned (H with addr[0]=1, W with addr[1:0]!=0): go to RESP with fault, unless the SPLIT feature applies.
  - otherwise: go to ISSUE.
- ISSUE: drive mem_req, mem_we, mem_addr, mem_be, mem_wdata from registers; hold them stable until mem_gnt. On mem_gnt, go to WAIT and clear the timeout counter.
- WAIT: on mem_rvalid, capture mem_rdata, go to RESP. If TIMEOUT!=0 and the counter reaches TIMEOUT without mem_rvalid, go to RESP with fault. mem_rvalid in the same cycle as expiry wins (no fault).
- RESP: resp_valid=1 for exactly one cycle, then IDLE. Minimum load latency: accept edge T, mem_req at T+1, gnt at T+1, rvalid at T+2, resp_valid at T+3.
- Byte enables:
  - B: 1<<addr[1:0]
  - H: 0011<<addr[1:0]
  - W: 1111
- Write data: SB replicates byte into all lanes; SH replicates halfword into both halves; SW passes through.
- Load extract: lane selected by addr[1:0]; LB/LH sign-extend; LBU/LHU zero-extend.
- Stores complete on mem_rvalid (write ack); resp_rdata=0.
- mem_gnt or mem_rvalid outside ISSUE/WAIT is ignored.
- req_valid while busy: not accepted; the requester must hold it.

Optional Feature:
- Macro LSU_MISALIGN_SPLIT_EN.
- Defined: misaligned H/W accesses not crossing a word are issued as one access with shifted BE. Word-crossing accesses issue two aligned accesses: low word (ISSUE/WAIT), then addr+4 (ISSUE2/WAIT2).
  - Bytes are merged before extension; resp_valid follows the second rvalid.
  - A timeout on either access faults; a store's first half is not rolled back.
- Undefined: any misaligned H/W faults without a bus access. ISSUE2/WAIT2 are absent.

Test Plan:
- LB addr=0x1003, mem_rdata=0x80AB_CDEF -> mem_be=1000, mem_addr=0x1000; resp_rdata=0xFFFF_FF80, fault=0.
- LHU addr=0x2002, mem_rdata=0x9123_4567 -> be=1100; rdata=0x0000_9123. SB addr=0x2001, wdata=0x55 -> mem_we=1, be=0010, mem_wdata=0x5555_5555.
- LW addr=0x10, mem_gnt delayed 3 cycles -> mem_req and mem_addr stable for 4 cycles; resp_valid exactly 1 cycle after mem_rvalid.
- LW addr=0x13, macro off -> no mem_req; resp_valid at T+1 with fault=1. Macro on, mem@0x10=0x44332211, mem@0x14=0x88776655 -> two accesses; rdata=0x77665544.
- TIMEOUT=4, gnt given, rvalid withheld -> fault on the 4th cycle after grant. Load funct3=011 -> immediate fault, no bus activity.
- rst_n low during WAIT -> outputs 0 asynchronously, req_ready=1. A stale mem_rvalid afterwards produces no resp_valid.

Source files
------------

// File: rtl/lsu_mem_ctrl_if.sv
// lsu_mem_ctrl_if: load/store unit request, response and data-memory bus bundle
//   req_valid/req_ready        execute-stage handshake; req_store, req_funct3, req_addr, req_wdata describe the access
//   resp_valid/resp_rdata/resp_fault  one-cycle completion with extended load data or fault
//   mem_req/mem_gnt            bus request held until grant; mem_we, mem_addr, mem_be, mem_wdata qualify it
//   mem_rvalid/mem_rdata       read data or write acknowledge
// Modports: master = the load/store controller, slave = execute stage plus memory around it.
interface lsu_mem_ctrl_if #(
  parameter int ADDR_W = 32
);
  logic              req_valid;
  logic              req_ready;
  logic              req_store;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_fault;
  logic              mem_req;
  logic              mem_gnt;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [3:0]        mem_be;
  logic [31:0]       mem_wdata;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;
  modport master (
    input  req_valid, req_store, req_funct3, req_addr, req_wdata, mem_gnt, mem_rvalid, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_fault, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
  modport slave (
    output req_valid, req_store, req_funct3, req_addr, req_wdata, mem_gnt, mem_rvalid, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_fault, mem_req, mem_we, mem_addr, mem_be, mem_wdata
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: RV32I load/store sequencer onto a single-port 32-bit data memory bus
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    lsu_mem_ctrl_if.master: req_* from execute, resp_* back to it, mem_* to the data memory
//   busy   controller is not IDLE
// Parameters: ADDR_W byte address width, TIMEOUT grant-to-rvalid cycle limit (0 disables it).
// Build option LSU_MISALIGN_SPLIT_EN: misaligned halfword/word accesses go to the bus, split into
// two aligned accesses when they cross a word; without it they fault with no bus activity.
module lsu_mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst_n,
  lsu_mem_ctrl_if.master bus,
  output logic           busy
);
`ifdef LSU_MISALIGN_SPLIT_EN
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, RESP, ISSUE2, WAIT2} state_t;
`else
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
`endif
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT + 1) : 1;
  state_t            state, state_nx;
  logic              store_q, fault_q;
  logic [2:0]        f3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q, word0_q, rdata_q;
  logic [CW-1:0]     cnt;
  logic [1:0]        off;
  logic              is_b, is_h, illegal, bad, hi, second, issuing, tout, capture, expire;
  logic [7:0]        be8;
  logic [63:0]       wd64;
  logic [31:0]       wd, ld, ext;
  assign off = addr_q[1:0];
  assign is_b = f3_q[1:0] == 2'b00;
  assign is_h = f3_q[1:0] == 2'b01;
  assign illegal = bus.req_funct3[1:0] == 2'b11 || (bus.req_store ? bus.req_funct3[2] : bus.req_funct3 == 3'b110);
`ifdef LSU_MISALIGN_SPLIT_EN
  logic cross;
  assign cross = (is_h && off == 2'b11) || (f3_q[1:0] == 2'b10 && off != 2'b00);
  assign hi = state == ISSUE2;
  assign second = state == WAIT2;
  assign bad = illegal;
`else
  assign hi = 1'b0;
  assign second = 1'b0;
  assign bad = illegal || (bus.req_funct3[1:0] == 2'b01 && bus.req_addr[0]) ||
               (bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] != 2'b00);
`endif
  // Byte enables and store data are built over an 8-byte window; the upper half feeds the
  // second access of a word-crossing split and is never selected otherwise.
  assign be8 = {4'b0000, is_b ? 4'b0001 : is_h ? 4'b0011 : 4'b1111} << off;
  assign wd64 = {32'h0, wdata_q} << {off, 3'b000};
  assign wd = is_b ? {4{wdata_q[7:0]}} : is_h && !off[0] ? {2{wdata_q[15:0]}} : hi ? wd64[63:32] : wd64[31:0];
  // Loads merge both words of a split before the lane shift, so extension sees whole bytes.
  assign ld = 32'((second ? {bus.mem_rdata, word0_q} : {32'h0, bus.mem_rdata}) >> {off, 3'b000});
  assign ext = is_b ? {{24{ld[7] & !f3_q[2]}}, ld[7:0]} : is_h ? {{16{ld[15] & !f3_q[2]}}, ld[15:0]} : ld;
  assign tout = TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1);
  assign issuing = state == ISSUE || hi;
  assign bus.req_ready = state == IDLE;
  assign busy = state != IDLE;
  assign bus.resp_valid = state == RESP;
  assign bus.resp_rdata = state == RESP ? rdata_q : 32'h0;
  assign bus.resp_fault = state == RESP && fault_q;
  assign bus.mem_req = issuing;
  assign bus.mem_we = issuing && store_q;
  assign bus.mem_addr = issuing ? {addr_q[ADDR_W-1:2] + (ADDR_W-2)'(hi), 2'b00} : '0;
  assign bus.mem_be = issuing ? (hi ? be8[7:4] : be8[3:0]) : 4'h0;
  assign bus.mem_wdata = issuing ? wd : 32'h0;
  always_comb begin
    state_nx = state;
    capture = 1'b0;
    expire = 1'b0;
    case (state)
      IDLE: if (bus.req_valid) state_nx = bad ? RESP : ISSUE;
      ISSUE: if (bus.mem_gnt) state_nx = WAIT;
`ifdef LSU_MISALIGN_SPLIT_EN
      WAIT:
        if (bus.mem_rvalid) begin
          state_nx = cross ? ISSUE2 : RESP;
          capture = !cross;
        end else if (tout) begin
          state_nx = RESP;
          expire = 1'b1;
        end
      ISSUE2: if (bus.mem_gnt) state_nx = WAIT2;
      WAIT2:
        if (bus.mem_rvalid) begin
          state_nx = RESP;
          capture = 1'b1;
        end else if (tout) begin
          state_nx = RESP;
          expire = 1'b1;
        end
`else
      WAIT:
        if (bus.mem_rvalid) begin
          state_nx = RESP;
          capture = 1'b1;
        end else if (tout) begin
          state_nx = RESP;
          expire = 1'b1;
        end
`endif
      RESP: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      store_q <= 1'b0;
      fault_q <= 1'b0;
      f3_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      word0_q <= '0;
      rdata_q <= '0;
      cnt <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.req_valid) begin
        store_q <= bus.req_store;
        f3_q <= bus.req_funct3;
        addr_q <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        fault_q <= bad;
        rdata_q <= '0;
      end
      if (issuing && bus.mem_gnt) cnt <= '0;
      else if (state == WAIT || second) cnt <= cnt + 1'b1;
      if (state == WAIT && bus.mem_rvalid) word0_q <= bus.mem_rdata;
      if (capture && !store_q) rdata_q <= ext;
      if (expire) fault_q <= 1'b1;
    end
  end
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: scoreboard bench for lsu_mem_ctrl with a reactive memory model
module tb_lsu_mem_ctrl;
  typedef struct packed {logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata;} bus_t;
  typedef struct packed {logic fault; logic [31:0] rdata;} resp_t;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic busy;
  int pass = 0, total = 0, cyc = 0;
  int acc_cyc = 0, gnt_cyc = 0, rv_cyc = 0, resp_cyc = 0, gnt_cnt = 0, g = 0;
  int gnt_delay = 0;
  bit rv_en = 1'b1;
  bit stale_req = 1'b0;
  bit [31:0] mem [bit [31:0]];
  bus_t exp_bus[$];
  resp_t exp_resp[$];
  lsu_mem_ctrl_if #(.ADDR_W(32)) bus ();
  lsu_mem_ctrl #(.ADDR_W(32), .TIMEOUT(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy));
  always #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end
  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask
  task automatic exp_acc(logic we, logic [31:0] a, logic [3:0] be, logic [31:0] wd);
    exp_bus.push_back({we, a, be, wd});
  endtask
  task automatic run(logic st, logic [2:0] f3, logic [31:0] a, logic [31:0] wd, bit want, logic ef, logic [31:0] er);
    int n;
    if (want) exp_resp.push_back({ef, er});
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_store = st;
    bus.req_funct3 = f3;
    bus.req_addr = a;
    bus.req_wdata = wd;
    for (n = 0; !bus.req_ready && n < 50; n++) @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    acc_cyc = cyc;
    bus.req_valid = 1'b0;
    if (want) begin
      for (n = 0; exp_resp.size() != 0 && n < 50; n++) @(negedge clk);
      chk("resp_within_budget", 32'(exp_resp.size()), 0);
      exp_resp.delete();
    end
  endtask
  // Memory model: checks each new bus request against the expected queue, holds grant off
  // for gnt_delay cycles, then returns rvalid one cycle after the grant.
  initial begin
    bus_t a, e;
    bus.mem_gnt = 1'b0;
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata = 32'h0;
    forever begin
      @(negedge clk);
      if (stale_req) begin
        bus.mem_rvalid = 1'b1;
        bus.mem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.mem_rvalid = 1'b0;
        stale_req = 1'b0;
      end else if (bus.mem_req) begin
        a = {bus.mem_we, bus.mem_addr, bus.mem_be, bus.mem_wdata};
        chk("mem_req_expected", 32'(exp_bus.size() != 0), 1);
        if (exp_bus.size() != 0) begin
          e = exp_bus.pop_front();
          chk("mem_we", 32'(a.we), 32'(e.we));
          chk("mem_addr", a.addr, e.addr);
          chk("mem_be", 32'(a.be), 32'(e.be));
          chk("mem_wdata", a.wdata, e.wdata);
        end
        for (int i = 0; i < gnt_delay; i++) begin
          @(negedge clk);
          chk("mem_req_held", 32'(bus.mem_req), 1);
          chk("mem_addr_held", bus.mem_addr, a.addr);
        end
        bus.mem_gnt = 1'b1;
        @(negedge clk);
        bus.mem_gnt = 1'b0;
        gnt_cyc = cyc;
        gnt_cnt++;
        if (rv_en) begin
          bus.mem_rvalid = 1'b1;
          bus.mem_rdata = a.we ? 32'h0 : mem[a.addr];
          rv_cyc = cyc;
          @(negedge clk);
          bus.mem_rvalid = 1'b0;
        end
      end
    end
  end
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (bus.resp_valid) begin
        resp_cyc = cyc;
        chk("resp_expected", 32'(exp_resp.size() != 0), 1);
        if (exp_resp.size() != 0) begin
          e = exp_resp.pop_front();
          chk("resp_rdata", bus.resp_rdata, e.rdata);
          chk("resp_fault", 32'(bus.resp_fault), 32'(e.fault));
        end
      end
    end
  end
  initial begin
    bus.req_valid = 1'b0;
    bus.req_store = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr = 32'h0;
    bus.req_wdata = 32'h0;
    mem[32'h1000] = 32'h80AB_CDEF;
    mem[32'h2000] = 32'h9123_4567;
    mem[32'h10] = 32'h4433_2211;
    mem[32'h14] = 32'h8877_6655;
    mem[32'h40] = 32'h8001_0000;
    mem[32'h20] = 32'h0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 1);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_mem_req", 32'(bus.mem_req), 0);
    chk("rst_resp_valid", 32'(bus.resp_valid), 0);
    chk("rst_mem_be", 32'(bus.mem_be), 0);
    rst_n = 1'b1;
    exp_acc(1'b0, 32'h1000, 4'b1000, 32'h0);
    run(1'b0, 3'b000, 32'h1003, 32'h0, 1'b1, 1'b0, 32'hFFFF_FF80);
    chk("load_min_latency", 32'(resp_cyc - acc_cyc), 2);
    exp_acc(1'b0, 32'h2000, 4'b1100, 32'h0);
    run(1'b0, 3'b101, 32'h2002, 32'h0, 1'b1, 1'b0, 32'h0000_9123);
    exp_acc(1'b1, 32'h2000, 4'b0010, 32'h5555_5555);
    run(1'b1, 3'b000, 32'h2001, 32'h0000_0055, 1'b1, 1'b0, 32'h0);
    exp_acc(1'b1, 32'h2000, 4'b1100, 32'hBEEF_BEEF);
    run(1'b1, 3'b001, 32'h2002, 32'h1234_BEEF, 1'b1, 1'b0, 32'h0);
    exp_acc(1'b1, 32'h30, 4'b1111, 32'hDEAD_BEEF);
    run(1'b1, 3'b010, 32'h30, 32'hDEAD_BEEF, 1'b1, 1'b0, 32'h0);
    exp_acc(1'b0, 32'h1000, 4'b0010, 32'h0);
    run(1'b0, 3'b100, 32'h1001, 32'h0, 1'b1, 1'b0, 32'h0000_00CD);
    exp_acc(1'b0, 32'h40, 4'b1100, 32'h0);
    run(1'b0, 3'b001, 32'h42, 32'h0, 1'b1, 1'b0, 32'hFFFF_8001);
    gnt_delay = 3;
    exp_acc(1'b0, 32'h10, 4'b1111, 32'h0);
    run(1'b0, 3'b010, 32'h10, 32'h0, 1'b1, 1'b0, 32'h4433_2211);
    chk("rvalid_to_resp", 32'(resp_cyc - rv_cyc), 1);
    gnt_delay = 0;
`ifdef LSU_MISALIGN_SPLIT_EN
    exp_acc(1'b0, 32'h10, 4'b1000, 32'h0);
    exp_acc(1'b0, 32'h14, 4'b0111, 32'h0);
    run(1'b0, 3'b010, 32'h13, 32'h0, 1'b1, 1'b0, 32'h7766_5544);
    exp_acc(1'b0, 32'h40, 4'b0110, 32'h0);
    run(1'b0, 3'b001, 32'h41, 32'h0, 1'b1, 1'b0, 32'h0000_0100);
`else
    run(1'b0, 3'b010, 32'h13, 32'h0, 1'b1, 1'b1, 32'h0);
    chk("misaligned_latency", 32'(resp_cyc - acc_cyc), 0);
    run(1'b0, 3'b001, 32'h41, 32'h0, 1'b1, 1'b1, 32'h0);
`endif
    run(1'b0, 3'b011, 32'h0, 32'h0, 1'b1, 1'b1, 32'h0);
    chk("illegal_latency", 32'(resp_cyc - acc_cyc), 0);
    run(1'b1, 3'b100, 32'h8, 32'h1234_5678, 1'b1, 1'b1, 32'h0);
    rv_en = 1'b0;
    exp_acc(1'b0, 32'h20, 4'b1111, 32'h0);
    run(1'b0, 3'b010, 32'h20, 32'h0, 1'b1, 1'b1, 32'h0);
    chk("timeout_cycles", 32'(resp_cyc - gnt_cyc), 4);
    exp_acc(1'b0, 32'h50, 4'b1111, 32'h0);
    g = gnt_cnt;
    run(1'b0, 3'b010, 32'h50, 32'h0, 1'b0, 1'b0, 32'h0);
    for (int n = 0; n < 20 && gnt_cnt == g; n++) @(negedge clk);
    chk("abort_granted", 32'(gnt_cnt - g), 1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_mem_req", 32'(bus.mem_req), 0);
    chk("abort_req_ready", 32'(bus.req_ready), 1);
    chk("abort_busy", 32'(busy), 0);
    chk("abort_resp_valid", 32'(bus.resp_valid), 0);
    @(negedge clk);
    rst_n = 1'b1;
    rv_en = 1'b1;
    stale_req = 1'b1;
    for (int n = 0; n < 20 && stale_req; n++) @(negedge clk);
    repeat (3) @(negedge clk);
    chk("stale_busy", 32'(busy), 0);
    repeat (3) @(negedge clk);
    chk("bus_queue_empty", 32'(exp_bus.size()), 0);
    chk("resp_queue_empty", 32'(exp_resp.size()), 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
